// File: rtl/rr_handshake_arbiter_pkg.sv
// Shared types and width helpers for the round-robin handshake arbiter.
package rr_handshake_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic int gnt_id_w(input int n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_handshake_arbiter_pick.sv
// Combinational round-robin winner search starting just after the last grant.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [N_REQ-1:0] win,
  output logic [IDW-1:0]   win_id
);

  logic           w_found;
  logic [IDW-1:0] w_idx;

  always_comb begin
    win     = '0;
    win_id  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = IDW'((int'(last) + i) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        win[w_idx] = 1'b1;
        win_id     = w_idx;
      end
    end
  end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter with a registered one-cycle req->gnt handshake,
// grant held until done or timeout, then one RELEASE cycle.
module rr_handshake_arbiter
  import rr_handshake_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic                       done,
  output logic [N_REQ-1:0]           gnt,
  output logic [gnt_id_w(N_REQ)-1:0] gnt_id,
  output logic                       start,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [7:0]                 served_cnt
);

  localparam int             IDW  = gnt_id_w(N_REQ);
  localparam int             CW   = cnt_w(TIMEOUT);
  localparam logic [CW-1:0]  TERM = CW'(TIMEOUT - 1);

  state_t           r_state, w_next;
  logic [N_REQ-1:0] r_gnt, w_win;
  logic [IDW-1:0]   r_gnt_id, r_last, w_win_id;
  logic [CW-1:0]    r_cnt;
  logic             r_start, r_tmo;
  logic [7:0]       r_served;
  logic             w_done_eff, w_term, w_req_any;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req    (req),
    .last   (r_last),
    .win    (w_win),
    .win_id (w_win_id)
  );

  // done coinciding with start belongs to no job the resource has seen yet
  assign w_done_eff = done & ~r_start;
  assign w_term     = (r_cnt == TERM);
  assign w_req_any  = |req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_req_any) w_next = ST_GRANT;
      ST_GRANT:   if (w_done_eff || w_term) w_next = ST_RELEASE;
      ST_RELEASE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_last   <= IDW'(N_REQ - 1);
      r_cnt    <= '0;
      r_start  <= 1'b0;
      r_tmo    <= 1'b0;
      r_served <= '0;
    end else begin
      r_start <= 1'b0;
      r_tmo   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_gnt    <= w_win;
            r_gnt_id <= w_win_id;
            r_start  <= 1'b1;
            r_cnt    <= '0;
          end
        end
        ST_GRANT: begin
          if (w_done_eff || w_term) begin
            r_gnt    <= '0;
            r_served <= r_served + 8'd1;
            r_last   <= r_gnt_id;
            r_tmo    <= ~w_done_eff;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RELEASE: r_gnt_id <= '0;
        default: begin
          r_gnt    <= '0;
          r_gnt_id <= '0;
        end
      endcase
    end
  end

  always_comb begin
    busy        = (r_state != ST_IDLE);
    gnt         = r_gnt;
    gnt_id      = r_gnt_id;
    start       = r_start;
    timeout_err = r_tmo;
    served_cnt  = r_served;
  end

endmodule

// File: doc/rr_handshake_arbiter.md
# rr_handshake_arbiter

Single-clock round-robin arbiter that shares one resource among `N_REQ` requesters using a request/grant/done handshake. A sampled request produces a one-hot grant exactly one cycle later. The grant is held until the resource signals `done` or a timeout expires. The block sits between requester agents and a shared datapath resource. Its fixed-latency handshake is the contract that the team's concurrent assertions (`req ##1 gnt`, grant-to-done bounds) check.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters; legal range 2..16.
- `TIMEOUT`, 15, maximum cycles a grant is held without `done`; legal range 2..255.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  N_REQ  request per requester; level, held until granted.
- `done`  in  1  resource finished the current job; single-cycle pulse.
- `gnt`  out  N_REQ  one-hot grant, registered.
- `gnt_id`  out  $clog2(N_REQ)  index of the granted requester; valid while `busy`.
- `start`  out  1  one-cycle pulse to the resource, coincident with the first cycle of `gnt`.
- `busy`  out  1  high in GRANT and RELEASE.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.
- `served_cnt`  out  8  count of completed grants (done or timeout); wraps 255 -> 0.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE, when `req` != 0:
  - Pick the winner round-robin, searching from `(last + 1) mod N_REQ` upward.
  - Register `gnt`, `gnt_id` and `start` = 1.
  - Clear the timeout counter to 0 and go to GRANT.
- IDLE, when `req` == 0: stay in IDLE; all outputs stay 0 except `served_cnt`.
- GRANT:
  - `start` is low after the first cycle.
  - The counter increments each cycle while `done` = 0.
  - `done` = 1, sampled in any GRANT cycle except the one with `start` = 1: go to RELEASE, clear `gnt`, increment `served_cnt`, set `last` = `gnt_id`.
  - `done` = 1 in the `start` cycle is ignored.
  - Counter == TIMEOUT-1 with `done` = 0: go to RELEASE, clear `gnt`, pulse `timeout_err`, increment `served_cnt`, set `last` = `gnt_id`.
  - `done` and the terminal count in the same cycle: `done` wins and `timeout_err` stays 0.
- RELEASE: `gnt` = 0 and `busy` = 1 for one cycle, then go to IDLE. Requests are not sampled in RELEASE.
- If a requester drops `req` while granted, the grant is unaffected; only `done` or the timeout ends it.
- Arithmetic:
  - Timeout counter width is $clog2(TIMEOUT+1), unsigned, and never exceeds TIMEOUT-1.
  - `served_cnt` is unsigned modulo 256.
- Reset (asynchronous, any state, including mid-grant):
  - State goes to IDLE.
  - `gnt`, `gnt_id`, `start`, `busy`, `timeout_err` and `served_cnt` go to 0.
  - `last` is set to N_REQ-1, so requester 0 has first priority.
  - Outputs drop immediately on `rst_n` falling, without waiting for a clock edge.
- After `rst_n` rises, the first edge may sample `req`.

## Timing
- Grant latency: `req` sampled in IDLE at edge t puts `gnt`, `start` and `busy` high in cycle t+1. This is exactly 1 cycle.
- Done path: `done` sampled at edge t+k (k >= 2) gives:
  - `gnt` low in cycle t+k+1 (RELEASE);
  - IDLE in cycle t+k+2;
  - the earliest next grant in cycle t+k+3.
- Minimum `gnt` low gap between consecutive grants: 2 cycles.
- Timeout with grant at t+1:
  - `gnt` is high for cycles t+1 .. t+TIMEOUT;
  - `timeout_err` = 1 and `gnt` = 0 in cycle t+TIMEOUT+1.
- `served_cnt` updates in the same cycle as the RELEASE entry.

## Structure
- Package `rr_handshake_arbiter_pkg` holds:
  - the state enum typedef (IDLE, GRANT, RELEASE);
  - a function returning $clog2-based widths for `gnt_id` and the counter.
- Sub-module `rr_pick`:
  - combinational;
  - inputs `req` and `last`;
  - outputs a one-hot winner and its index;
  - instantiated once.
- Top level holds the FSM, timeout counter, `last` pointer and `served_cnt`.

## Test plan
- Single request: `req` = 4'b0100 at edge 1 -> `gnt` = 4'b0100, `gnt_id` = 2, `start` = 1 in cycle 2. `done` at cycle 5 -> `gnt` = 0 in cycle 6, `served_cnt` = 1.
- Round robin: `req` = 4'b1111 held with `done` 3 cycles after each start -> grant order 0, 1, 2, 3, 0. The `gnt` low gap is 2 cycles each time.
- Timeout: `req` = 4'b0001, `done` never asserted, TIMEOUT = 15 -> `gnt` high for 15 cycles, then `timeout_err` pulses once and `served_cnt` increments.
- Boundary cases:
  - `done` in the `start` cycle -> ignored, grant continues.
  - `done` at counter == 14 -> normal release, `timeout_err` = 0.
- Reset mid-grant: drop `rst_n` while `gnt` = 4'b0010 -> all outputs 0 immediately. After release with `req` = 4'b1010, the first grant goes to requester 1.
- Counter wrap: perform 256 grant cycles -> `served_cnt` goes 255 -> 0, with no effect on arbitration.
